// File: rtl/instr_encoder.sv
// Packs an operation select plus register/immediate fields into a 32-bit ISA word
// and streams the words into imem through a 2-entry FIFO with ready/valid on both sides.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [16:0]       imm,
  input  logic [26:0]       target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_illegal,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII
  } fmt_e;

  fmt_e        fmt;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic        use_shamt;
  logic        legal;
  logic [31:0] enc_word;

  always_comb begin
    fmt       = FMT_R;
    opcode    = 5'b00000;
    alu_op    = 5'd0;
    use_shamt = 1'b0;
    legal     = 1'b1;
    case (op_sel)
      5'd0:  alu_op = 5'd0;
      5'd1:  begin opcode = 5'b00101; fmt = FMT_I; end
      5'd2:  alu_op = 5'd1;
      5'd3:  alu_op = 5'd2;
      5'd4:  alu_op = 5'd3;
      5'd5:  begin alu_op = 5'd4; use_shamt = 1'b1; end
      5'd6:  begin alu_op = 5'd5; use_shamt = 1'b1; end
      5'd7:  alu_op = 5'd6;
      5'd8:  alu_op = 5'd7;
      5'd9:  begin opcode = 5'b00111; fmt = FMT_I; end
      5'd10: begin opcode = 5'b01000; fmt = FMT_I; end
      5'd11: begin opcode = 5'b00001; fmt = FMT_JI; end
      5'd12: begin opcode = 5'b00010; fmt = FMT_I; end
      5'd13: begin opcode = 5'b00110; fmt = FMT_I; end
      5'd14: begin opcode = 5'b00011; fmt = FMT_JI; end
      5'd15: begin opcode = 5'b00100; fmt = FMT_JII; end
      5'd16: begin opcode = 5'b10110; fmt = FMT_JI; end
      5'd17: begin opcode = 5'b10101; fmt = FMT_JI; end
      default: legal = 1'b0;
    endcase
  end

  // Fields a format does not use are left out entirely rather than masked later.
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_R:   enc_word = {opcode, rd, rs, rt, (use_shamt ? shamt : 5'd0), alu_op, 2'b00};
      FMT_I:   enc_word = {opcode, rd, rs, imm};
      FMT_JI:  enc_word = {opcode, target};
      FMT_JII: enc_word = {opcode, rd, 22'd0};
      default: enc_word = 32'd0;
    endcase
  end

  logic [31:0]       mem_q [2];
  logic [31:0]       mem_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              accept, push, pop;

  // in_ready comes from the registered occupancy, so a same-cycle pop never admits a push.
  assign in_ready = (cnt_q != 2'd2);
  assign wr_valid = (cnt_q != 2'd0);
  assign wr_data  = wr_valid ? mem_q[rptr_q] : 32'd0;
  assign wr_addr  = addr_q;
  assign wr_count = count_q;
  assign err_illegal = err_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign pop    = wr_valid & wr_ready;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = enc_word;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = accept & ~legal;
    if (addr_load) begin
      addr_d = addr_base;
    end else if (pop) begin
      addr_d = addr_q + 1'b1;
    end
    if (pop && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= 32'd0;
      mem_q[1] <= 32'd0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      count_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed encoding vectors, directed flow-control/address/reset
// sequences, and random traffic checked every cycle against a queue-based reference.
module tb_instr_encoder;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        op_sel = '0, rd = '0, rs = '0, rt = '0, shamt = '0;
  logic [16:0]       imm = '0;
  logic [26:0]       target = '0;
  logic              addr_load = 1'b0;
  logic [ADDR_W-1:0] addr_base = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err_illegal;
  logic [15:0]       wr_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .imm(imm), .target(target),
    .addr_load(addr_load), .addr_base(addr_base), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_illegal(err_illegal), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  // Opcode, alu_op and format (0 R, 1 I, 2 JI, 3 JII) for each legal op_sel.
  localparam int OPC [0:17] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 7, 8, 1, 2, 6, 3, 4, 22, 21};
  localparam int ALU [0:17] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int FMT [0:17] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 2, 3, 2, 2};

  function automatic logic [31:0] ref_enc(input longint op, input longint f_rd, input longint f_rs,
                                          input longint f_rt, input longint f_sh, input longint f_imm,
                                          input longint f_tgt);
    longint w;
    w = longint'(OPC[op]) * 134217728;
    case (FMT[op])
      0: w = w + f_rd * 4194304 + f_rs * 131072 + f_rt * 4096
           + ((op == 5 || op == 6) ? f_sh : 0) * 128 + longint'(ALU[op]) * 4;
      1: w = w + f_rd * 4194304 + f_rs * 131072 + f_imm;
      2: w = w + f_tgt;
      default: w = w + f_rd * 4194304;
    endcase
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, address and count as plain integers.
  logic [31:0] m_q[$];
  int          m_addr = 0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;

  always @(negedge clock) begin
    bit hs, acc;
    if (!reset_n) begin
      m_q.delete();
      m_addr = 0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end
    chk("mon_in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    chk("mon_wr_valid", 32'(wr_valid), 32'(m_q.size() > 0));
    chk("mon_wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("mon_wr_count", 32'(wr_count), 32'(m_cnt));
    chk("mon_err_illegal", 32'(err_illegal), 32'(m_err));
    if (m_q.size() > 0) chk("mon_wr_data", wr_data, m_q[0]);
    if (reset_n) begin
      hs  = (m_q.size() > 0) && wr_ready;
      acc = in_valid && (m_q.size() < 2);
      if (hs) begin
        void'(m_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (addr_load) m_addr = int'(addr_base);
      else if (hs) m_addr = (m_addr + 1) % (1 << ADDR_W);
      m_err = acc && (op_sel > 17);
      if (acc && op_sel <= 17)
        m_q.push_back(ref_enc(op_sel, rd, rs, rt, shamt, imm, target));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs,
                      input logic [4:0] f_rt, input logic [4:0] f_sh, input logic [16:0] f_imm,
                      input logic [26:0] f_tgt);
    int n;
    op_sel = op; rd = f_rd; rs = f_rs; rt = f_rt; shamt = f_sh; imm = f_imm; target = f_tgt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    wr_ready = 1'b1;
    n = 0;
    while (wr_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("drain_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct packed {
    logic [4:0]  op, f_rd, f_rs, f_rt, f_sh;
    logic [16:0] f_imm;
    logic [26:0] f_tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int waited;
    logic [15:0] cnt_before;
    logic [ADDR_W-1:0] addr_before;

    // unused fields carry junk to prove they are ignored
    vecs[0]  = '{5'd0,  5'd3,  5'd1,  5'd2,  5'd9,  17'h1ABCD, 27'h5555555, 32'h00C22000};
    vecs[1]  = '{5'd5,  5'd2,  5'd1,  5'd0,  5'd4,  17'h0,     27'h0,       32'h00820210};
    vecs[2]  = '{5'd1,  5'd1,  5'd0,  5'd31, 5'd31, 17'd5,     27'h7FFFFFF, 32'h28400005};
    vecs[3]  = '{5'd11, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'd100,     32'h08000064};
    vecs[4]  = '{5'd2,  5'd5,  5'd6,  5'd7,  5'd9,  17'h00F0F, 27'h0,       32'h014C7004};
    vecs[5]  = '{5'd15, 5'd31, 5'd3,  5'd4,  5'd5,  17'h1FFFF, 27'h7FFFFFF, 32'h27C00000};
    vecs[6]  = '{5'd6,  5'd1,  5'd2,  5'd3,  5'd31, 17'h12345, 27'h0,       32'h00443F94};
    vecs[7]  = '{5'd16, 5'd7,  5'd7,  5'd7,  5'd7,  17'h1FFFF, 27'h7FFFFFF, 32'hB7FFFFFF};
    vecs[8]  = '{5'd10, 5'd2,  5'd3,  5'd9,  5'd9,  17'h1FFFF, 27'h1234567, 32'h4087FFFF};
    vecs[9]  = '{5'd17, 5'd1,  5'd1,  5'd1,  5'd1,  17'h1FFFF, 27'd5,       32'hA8000005};
    vecs[10] = '{5'd13, 5'd4,  5'd5,  5'd31, 5'd3,  17'h10000, 27'h0,       32'h310B0000};
    vecs[11] = '{5'd8,  5'd1,  5'd1,  5'd1,  5'd7,  17'h0,     27'h3FFFFFF, 32'h0042101C};

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Encoding vectors: one-cycle latency, word visible with its address.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].f_rd, vecs[i].f_rs, vecs[i].f_rt, vecs[i].f_sh,
           vecs[i].f_imm, vecs[i].f_tgt);
      waited = 0;
      while (!wr_valid && waited < 10) begin
        tick();
        waited++;
      end
      chk("vec_latency", 32'(waited), 32'd0);
      chk("vec_addr", 32'(wr_addr), 32'(i));
      chk("vec_data", wr_data, vecs[i].exp);
      $display("vec %0d op_sel=%0d wr_addr=%0d wr_data=0x%08h", i, vecs[i].op, wr_addr, wr_data);
      tick();
    end

    // Back-pressure: third word stalls until space frees up.
    do_reset();
    wr_ready = 1'b0;
    op_sel = 5'd0; rd = 5'd1; rs = 5'd2; rt = 5'd3; in_valid = 1'b1;
    tick();
    rd = 5'd4;
    tick();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    rd = 5'd7;
    tick();
    tick();
    chk("bp_stable_addr", 32'(wr_addr), 32'd0);
    chk("bp_stable_data", wr_data, 32'h00443000);
    wr_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 10) begin
      tick();
      waited++;
    end
    tick();
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(wr_count), 32'd3);
    chk("bp_addr_after", 32'(wr_addr), 32'd3);
    $display("backpressure: wr_count=%0d wr_addr=%0d", wr_count, wr_addr);

    // Illegal op_sel: pulse only, nothing written.
    cnt_before = wr_count;
    addr_before = wr_addr;
    send(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
    chk("ill_err_pulse", 32'(err_illegal), 32'd1);
    chk("ill_no_valid", 32'(wr_valid), 32'd0);
    tick();
    chk("ill_err_drop", 32'(err_illegal), 32'd0);
    chk("ill_count", 32'(wr_count), 32'(cnt_before));
    chk("ill_addr", 32'(wr_addr), 32'(addr_before));
    $display("illegal: err_illegal pulsed, wr_count=%0d", wr_count);

    // Address wrap and load/write collision.
    addr_load = 1'b1; addr_base = 12'hFFF;
    tick();
    addr_load = 1'b0;
    chk("wrap_loaded", 32'(wr_addr), 32'hFFF);
    send(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd1);
    chk("wrap_first_addr", 32'(wr_addr), 32'hFFF);
    send(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd2);
    chk("wrap_second_addr", 32'(wr_addr), 32'h000);
    drain();
    wr_ready = 1'b0;
    send(5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd3);
    addr_load = 1'b1; addr_base = 12'h123; wr_ready = 1'b1;
    chk("coll_old_addr", 32'(wr_addr), 32'h001);
    tick();
    addr_load = 1'b0;
    chk("coll_base_addr", 32'(wr_addr), 32'h123);
    $display("addr: wrap and load/write collision done, wr_addr=0x%03h", wr_addr);

    // Reset with two words queued.
    wr_ready = 1'b0;
    send(5'd3, 5'd1, 5'd1, 5'd1, 5'd0, 17'd0, 27'd0);
    send(5'd4, 5'd2, 5'd2, 5'd2, 5'd0, 17'd0, 27'd0);
    chk("mid_full", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(wr_valid), 32'd0);
    chk("mid_rst_count", 32'(wr_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    wr_ready = 1'b1;
    tick();
    send(5'd7, 5'd9, 5'd8, 5'd7, 5'd0, 17'd0, 27'd0);
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_valid", 32'(wr_valid), 32'd1);
    drain();
    $display("reset mid-stream: first word at addr 0");

    // Random traffic, checked cycle by cycle by the reference model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op_sel    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      rd        = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom); shamt = 5'($urandom);
      imm       = 17'($urandom); target = 27'($urandom);
      wr_ready  = ($urandom_range(0, 2) != 0);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_base = ADDR_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    addr_load = 1'b0;
    drain();
    $display("random: wr_count=%0d", wr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
